// File: rtl/imem_responder.sv
// Dual-lane synthesizable instruction memory with a fixed-latency response pipeline.
// Serves the fetch stage's imem request/response protocol and has a program-load write port.
module imem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           imem_ren,
  input  logic [XLEN-1:0]                imem_addr0,
  input  logic [XLEN-1:0]                imem_addr1,
  input  logic                           flush,
  input  logic                           prog_we,
  input  logic [XLEN-1:0]                prog_addr,
  input  logic [31:0]                    prog_wdata,
  output logic                           imem_valid,
  output logic [XLEN-1:0]                imem_rdata0,
  output logic [XLEN-1:0]                imem_rdata1,
  output logic [XLEN-1:0]                imem_pc [1:0],
  output logic [1:0]                     imem_fault,
  output logic [$clog2(LATENCY+1):0]     imem_inflight
);

  localparam int IW   = $clog2(LATENCY+1) + 1;
  localparam int AIW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST = LATENCY - 1;

  // A lane faults when it is not word aligned or its word index lies past the array.
  function automatic logic addr_fault(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= XLEN'(DEPTH));
  endfunction

  function automatic logic [AIW-1:0] word_index(input logic [XLEN-1:0] a);
    return a[AIW+1:2];
  endfunction

  logic [31:0]      mem_r [DEPTH];

  logic             stg_valid_r [LATENCY];
  logic [XLEN-1:0]  stg_pc0_r   [LATENCY];
  logic [XLEN-1:0]  stg_pc1_r   [LATENCY];
  logic [XLEN-1:0]  stg_data0_r [LATENCY];
  logic [XLEN-1:0]  stg_data1_r [LATENCY];
  logic [1:0]       stg_fault_r [LATENCY];
  logic [IW-1:0]    inflight_r;

  logic             fault0_s;
  logic             fault1_s;
  logic [XLEN-1:0]  rd0_s;
  logic [XLEN-1:0]  rd1_s;
  logic             prog_ok_s;

  // Per-lane lookup with faulting lanes forced to zero.
  always_comb begin
    fault0_s  = addr_fault(imem_addr0);
    fault1_s  = addr_fault(imem_addr1);
    prog_ok_s = prog_we && !addr_fault(prog_addr);
    if (fault0_s) begin
      rd0_s = {XLEN{1'b0}};
    end else begin
      rd0_s = XLEN'(mem_r[word_index(imem_addr0)]);
    end
    if (fault1_s) begin
      rd1_s = {XLEN{1'b0}};
    end else begin
      rd1_s = XLEN'(mem_r[word_index(imem_addr1)]);
    end
  end

  // Program-load write port; reads in the same cycle see the pre-write word.
  always_ff @(posedge clk) begin
    if (prog_ok_s) begin
      mem_r[word_index(prog_addr)] <= prog_wdata;
    end
  end

  // Response pipeline: data in each stage only moves with a live entry, so the
  // last stage keeps the most recent surviving response while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        stg_valid_r[k] <= 1'b0;
        stg_pc0_r[k]   <= {XLEN{1'b0}};
        stg_pc1_r[k]   <= {XLEN{1'b0}};
        stg_data0_r[k] <= {XLEN{1'b0}};
        stg_data1_r[k] <= {XLEN{1'b0}};
        stg_fault_r[k] <= 2'b00;
      end
      inflight_r <= {IW{1'b0}};
    end else begin
      stg_valid_r[0] <= imem_ren;
      if (imem_ren) begin
        stg_pc0_r[0]   <= imem_addr0;
        stg_pc1_r[0]   <= imem_addr1;
        stg_data0_r[0] <= rd0_s;
        stg_data1_r[0] <= rd1_s;
        stg_fault_r[0] <= {fault1_s, fault0_s};
      end
      for (int k = 1; k < LATENCY; k++) begin
        stg_valid_r[k] <= stg_valid_r[k-1] && !flush;
        if (stg_valid_r[k-1] && !flush) begin
          stg_pc0_r[k]   <= stg_pc0_r[k-1];
          stg_pc1_r[k]   <= stg_pc1_r[k-1];
          stg_data0_r[k] <= stg_data0_r[k-1];
          stg_data1_r[k] <= stg_data1_r[k-1];
          stg_fault_r[k] <= stg_fault_r[k-1];
        end
      end
      // A flush leaves only the same-cycle request (if any) in flight.
      if (flush) begin
        inflight_r <= IW'(imem_ren);
      end else begin
        inflight_r <= inflight_r + IW'(imem_ren) - IW'(stg_valid_r[LAST]);
      end
    end
  end

  assign imem_valid    = stg_valid_r[LAST];
  assign imem_rdata0   = stg_data0_r[LAST];
  assign imem_rdata1   = stg_data1_r[LAST];
  assign imem_pc[0]    = stg_pc0_r[LAST];
  assign imem_pc[1]    = stg_pc1_r[LAST];
  assign imem_fault    = stg_fault_r[LAST];
  assign imem_inflight = inflight_r;

endmodule
